// File: rtl/key_sched_ctrl.sv
// Sequential AES-128 key scheduler: one shared SubWord/Rcon datapath reused per round, 11-entry key bank.
// Optional macro KEY_SCHED_SBOX_REG_EN registers the SubWord output, so each round takes two cycles.
module key_sched_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  output logic         rk_valid,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk_data,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
`ifdef KEY_SCHED_SBOX_REG_EN
    ST_SUB    = 2'd2,
`endif
    ST_EXPAND = 2'd1
  } state_t;

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t         state_r, state_next;
  logic [3:0]     r_r;
  logic [127:0]   w_r;
  logic [127:0]   bank_r [0:10];
  logic           busy_r, done_r, keys_valid_r, rk_valid_r;
  logic [3:0]     rk_idx_r;
  logic [127:0]   rk_data_r, rd_key_r;
  logic           accept_s, round_wr_s;
  logic [31:0]    t_s, t_use_s;
  logic [31:0]    n0_s, n1_s, n2_s, n3_s;
  logic [127:0]   next_w_s;

  assign t_s = sub_word(rot_word(w_r[31:0])) ^ {rcon(r_r), 24'h000000};

`ifdef KEY_SCHED_SBOX_REG_EN
  logic           sub_load_s;
  logic [31:0]    t_r;

  // SubWord pipeline register, loaded in SUB while W is stable
  always_ff @(posedge clk) begin
    if (rst) begin
      t_r <= 32'h00000000;
    end else if (sub_load_s) begin
      t_r <= t_s;
    end
  end
  assign t_use_s = t_r;
`else
  assign t_use_s = t_s;
`endif

  assign n0_s     = w_r[127:96] ^ t_use_s;
  assign n1_s     = w_r[95:64]  ^ n0_s;
  assign n2_s     = w_r[63:32]  ^ n1_s;
  assign n3_s     = w_r[31:0]   ^ n2_s;
  assign next_w_s = {n0_s, n1_s, n2_s, n3_s};

  // Next-state and round strobes; busy_r still high in IDLE marks the drain cycle after done
  always_comb begin
    state_next = state_r;
    accept_s   = 1'b0;
    round_wr_s = 1'b0;
`ifdef KEY_SCHED_SBOX_REG_EN
    sub_load_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start && !busy_r) begin
          accept_s   = 1'b1;
`ifdef KEY_SCHED_SBOX_REG_EN
          state_next = ST_SUB;
`else
          state_next = ST_EXPAND;
`endif
        end else begin
          state_next = ST_IDLE;
        end
      end
`ifdef KEY_SCHED_SBOX_REG_EN
      ST_SUB: begin
        sub_load_s = 1'b1;
        state_next = ST_EXPAND;
      end
`endif
      ST_EXPAND: begin
        round_wr_s = 1'b1;
        if (r_r == 4'd10) begin
          state_next = ST_IDLE;
        end else begin
`ifdef KEY_SCHED_SBOX_REG_EN
          state_next = ST_SUB;
`else
          state_next = ST_EXPAND;
`endif
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Working key, round counter, status flags and stream beat
  always_ff @(posedge clk) begin
    if (rst) begin
      r_r          <= 4'd0;
      w_r          <= 128'h0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      keys_valid_r <= 1'b0;
      rk_valid_r   <= 1'b0;
      rk_idx_r     <= 4'd0;
      rk_data_r    <= 128'h0;
    end else begin
      done_r     <= 1'b0;
      rk_valid_r <= 1'b0;
      if (accept_s) begin
        w_r          <= key_in;
        r_r          <= 4'd1;
        busy_r       <= 1'b1;
        keys_valid_r <= 1'b0;
        rk_valid_r   <= 1'b1;
        rk_idx_r     <= 4'd0;
        rk_data_r    <= key_in;
      end else if (round_wr_s) begin
        w_r        <= next_w_s;
        r_r        <= r_r + 4'd1;
        rk_valid_r <= 1'b1;
        rk_idx_r   <= r_r;
        rk_data_r  <= next_w_s;
        if (r_r == 4'd10) begin
          done_r       <= 1'b1;
          keys_valid_r <= 1'b1;
        end
      end else if (done_r) begin
        busy_r <= 1'b0;
      end
    end
  end

  // Round-key bank; contents are masked by keys_valid so no reset is needed
  always_ff @(posedge clk) begin
    if (accept_s) begin
      bank_r[0] <= key_in;
    end else if (round_wr_s) begin
      bank_r[r_r] <= next_w_s;
    end
  end

  // Registered read port; old data is returned when reading the entry being written
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key_r <= 128'h0;
    end else if (keys_valid_r && (rd_idx <= 4'd10)) begin
      rd_key_r <= bank_r[rd_idx];
    end else begin
      rd_key_r <= 128'h0;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign keys_valid = keys_valid_r;
  assign rk_valid   = rk_valid_r;
  assign rk_idx     = rk_idx_r;
  assign rk_data    = rk_data_r;
  assign rd_key     = rd_key_r;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Self-checking bench for key_sched_ctrl; reference schedule built from the FIPS-197 word recurrence
// with an S-box derived from GF(2^8) inversion. Follows KEY_SCHED_SBOX_REG_EN for beat spacing.
module tb_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [127:0] key_in;
  logic         busy, done, keys_valid, rk_valid;
  logic [3:0]   rk_idx, rd_idx;
  logic [127:0] rk_data, rd_key;

  int checks   = 0;
  int failures = 0;

`ifdef KEY_SCHED_SBOX_REG_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int P = 10 * STEP + 2;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [7:0]   sbox_m [0:255];
  logic [127:0] exp_rk [0:10];
  logic [127:0] got    [0:10];

  key_sched_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in),
    .busy(busy), .done(done), .keys_valid(keys_valid),
    .rk_valid(rk_valid), .rk_idx(rk_idx), .rk_data(rk_data),
    .rd_idx(rd_idx), .rd_key(rd_key)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox;
    logic [7:0] inv;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++)
        if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      sbox_m[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 11; k++) exp_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  function automatic logic [127:0] exp_rd(input logic [3:0] idx);
    return (idx <= 4'd10) ? exp_rk[idx] : 128'h0;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called in cycle T+1 after acceptance at edge T; returns in cycle T+P with busy low.
  task automatic watch(input string tag, input bit inject);
    logic [127:0] last;
    int           lastk, k;
    bit           ev;
    last  = 128'h0;
    lastk = 0;
    for (int off = 1; off <= P; off++) begin
      k  = (off - 1) / STEP;
      ev = ((off - 1) % STEP == 0) && (k <= 10);
      chk({tag, "_valid"}, 128'(rk_valid), 128'(ev));
      chk({tag, "_busy"}, 128'(busy), 128'(off <= P - 1));
      chk({tag, "_done"}, 128'(done), 128'(off == P - 1));
      chk({tag, "_kvalid"}, 128'(keys_valid), 128'(off >= P - 1));
      if (ev) begin
        chk({tag, "_idx"}, 128'(rk_idx), 128'(k));
        chk({tag, "_data"}, rk_data, exp_rk[k]);
        got[k] = rk_data;
        last   = exp_rk[k];
        lastk  = k;
      end else begin
        chk({tag, "_hold_idx"}, 128'(rk_idx), 128'(lastk));
        chk({tag, "_hold_data"}, rk_data, last);
      end
      if (off >= 2 && off <= P - 1) chk({tag, "_rd_masked"}, rd_key, 128'h0);
      if (inject && off == 5) begin
        start  = 1'b1;
        key_in = rand_key();
      end
      if (inject && off == 6) start = 1'b0;
      if (off < P) tick;
    end
    chk({tag, "_rd_end"}, rd_key, exp_rd(rd_idx));
  endtask

  initial begin
    logic [127:0] k;
    logic [3:0]   ri;
    bit           seen;

    build_sbox;
    rst = 1'b1; start = 1'b0; key_in = 128'h0; rd_idx = 4'd0;
    tick; tick;
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_done", 128'(done), 128'h0);
    chk("rst_kvalid", 128'(keys_valid), 128'h0);
    chk("rst_rkvalid", 128'(rk_valid), 128'h0);
    chk("rst_rkidx", 128'(rk_idx), 128'h0);
    chk("rst_rkdata", rk_data, 128'h0);
    chk("rst_rdkey", rd_key, 128'h0);
    rst = 1'b0;

    // FIPS-197 key
    model(FIPS_KEY);
    rd_idx = 4'd10;
    start = 1'b1; key_in = FIPS_KEY; tick; start = 1'b0;
    watch("fips", 1'b0);
    chk("fips_rk0", got[0], FIPS_KEY);
    chk("fips_rk1", got[1], FIPS_RK1);
    chk("fips_rk10", got[10], FIPS_RK10);

    // All-zero key plus bank reads
    model(128'h0);
    rd_idx = 4'd3;
    start = 1'b1; key_in = 128'h0; tick; start = 1'b0;
    watch("zero", 1'b0);
    chk("zero_rk1", got[1], ZERO_RK1);
    chk("zero_rk10", got[10], ZERO_RK10);
    rd_idx = 4'd10; tick;
    chk("zero_rd10", rd_key, ZERO_RK10);
    rd_idx = 4'd11; tick;
    chk("zero_rd11", rd_key, 128'h0);
    for (int i = 0; i < 8; i++) begin
      ri = 4'($urandom_range(0, 15));
      rd_idx = ri; tick;
      chk("rand_rd", rd_key, exp_rd(ri));
    end

    // Start while busy is ignored
    model(FIPS_KEY);
    start = 1'b1; key_in = FIPS_KEY; tick; start = 1'b0;
    watch("busy_start", 1'b1);
    chk("busy_start_rk10", got[10], FIPS_RK10);

    // Reset mid-expansion
    start = 1'b1; key_in = rand_key(); tick; start = 1'b0;
    for (int i = 0; i < 5; i++) tick;
    rst = 1'b1; tick; rst = 1'b0;
    chk("midrst_busy", 128'(busy), 128'h0);
    chk("midrst_rkvalid", 128'(rk_valid), 128'h0);
    chk("midrst_kvalid", 128'(keys_valid), 128'h0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      seen = seen | done | rk_valid;
      tick;
    end
    chk("midrst_quiet", 128'(seen), 128'h0);
    for (int i = 0; i < 3; i++) begin
      k = rand_key();
      model(k);
      rd_idx = 4'($urandom_range(0, 15));
      start = 1'b1; key_in = k; tick; start = 1'b0;
      watch("rand", 1'b0);
    end

    // Back-to-back with start held high
    model(128'h0);
    rd_idx = 4'd10;
    start = 1'b1; key_in = 128'h0; tick;
    key_in = FIPS_KEY;
    watch("b2b_a", 1'b0);
    model(FIPS_KEY);
    tick; start = 1'b0;
    chk("b2b_busy_rise", 128'(busy), 128'h1);
    chk("b2b_kvalid_drop", 128'(keys_valid), 128'h0);
    watch("b2b_b", 1'b0);
    chk("b2b_rk10", got[10], FIPS_RK10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_sched_ctrl.md
# key_sched_ctrl

Sequential AES-128 round-key scheduler. Replaces the unrolled all-at-once key expansion with one shared SubWord/Rcon datapath that is reused once per round under a small FSM. It accepts a 128-bit cipher key on a start handshake and streams round keys 0..10 to the cipher round engine as they are produced. It also holds all 11 round keys in a register bank with a random-access read port for decryption-order access.

## Interface
- No parameters. The key size is fixed at 128 bits, with 10 rounds and 11 round keys.
- `clk` input 1: the single clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request to expand `key_in`. Sampled only when `busy`=0.
- `key_in` input 128: cipher key. Bits [127:96] are w0 and bits [31:0] are w3. Sampled on the cycle `start` is accepted.
- `busy` output 1: an expansion is in progress.
- `done` output 1: one-cycle pulse, coincident with the round-10 stream beat.
- `keys_valid` output 1: the bank holds a complete schedule.
- `rk_valid` output 1: stream beat qualifier, one cycle per round key.
- `rk_idx` output 4: round number (0..10) of `rk_data`.
- `rk_data` output 128: round key for the current stream beat.
- `rd_idx` input 4: bank read index.
- `rd_key` output 128: registered bank read data.

## Operation
**FSM states**
- IDLE, EXPAND, and SUB (SUB exists only with the macro enabled).
- IDLE → EXPAND when `start` is sampled in IDLE.
- EXPAND → IDLE after round 10 is written.

**Start acceptance**
- Latch `key_in` into working register W.
- Write bank[0] = `key_in`.
- Set round counter r = 1.
- Clear `keys_valid`.

**Per round r (1..10)**
- t = SubWord(RotWord(W.w3)) ^ {Rcon[r], 24'h0}.
- Rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
- W ← {n0,n1,n2,n3}, bank[r] ← W, r ← r+1.
- One 4-byte S-box instance is shared across all rounds; there is no per-round S-box replication.

**Stream output**
- Exactly 11 beats per expansion, with `rk_idx` = 0, 1, …, 10 in order and no gaps.
- `rk_data` and `rk_idx` hold their last values when `rk_valid`=0.

**Bank read**
- `rd_key` ← bank[`rd_idx`] on every cycle. Read latency is 1.
- `rd_key` = 0 when `rd_idx` > 10 or `keys_valid`=0.
- A read of an index during the cycle it is written returns the old value.

**Boundaries**
- `start` while `busy`=1 is ignored. It is neither queued nor able to corrupt W.
- `keys_valid` sets together with `done` and stays set until the next accepted `start` or `rst`.

## Timing
- `start` accepted at edge T (macro off):
  - `busy`=1 during cycles T+1..T+11.
  - Beat for round k occurs at T+1+k, so round 0 is at T+1 and round 10 is at T+11.
  - `done`=1 and `keys_valid`→1 at T+11.
  - `busy`=0 at T+12, and a new `start` can be accepted at edge T+12.
- Back-to-back use: holding `start` high continuously gives one expansion every 12 cycles.

**Reset (`rst`=1 at an edge)**
- State → IDLE and r = 0.
- `busy`, `done`, `keys_valid`, `rk_valid` = 0.
- `rk_idx` = 0, `rk_data` = 0, `rd_key` = 0.
- Bank contents are don't-care because `keys_valid` masks them.
- Reset mid-expansion aborts immediately: no further beats and no `done`.
- `rst` takes priority over a simultaneous `start`.

## Configuration
- `KEY_SCHED_SBOX_REG_EN`: adds a pipeline register on the SubWord output to shorten the critical path.
- Defined:
  - Each round takes two cycles, SUB (register t) then EXPAND (combine and write).
  - Round 0 beat at T+1, round k beat at T+1+2k.
  - `done` at T+21, `busy` high for T+1..T+21.
  - Key values are identical to the undefined case.
- Undefined: the single-cycle-per-round timing given in Timing above.

## Test plan
- **FIPS-197 key.** Start with key 2b7e151628aed2a6abf7158809cf4f3c.
  - Beat idx0 = the key itself.
  - idx1 = a0fafe1788542cb123a339392a6c7605.
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with `done` at T+11.
- **All-zero key.**
  - idx1 = 62636363626363636263636362636363.
  - idx10 = b4ef5bcb3e92e21123e951cf6f8f188e.
  - After done, `rd_idx`=10 returns the same value one cycle later, and `rd_idx`=11 returns 0.
- **Start while busy.** Pulse `start` with a different key at T+5. The stream must be unchanged: 11 beats, FIPS values, `done` at T+11.
- **Reset mid-operation.** Assert `rst` at T+6.
  - Next cycle: `busy`=`rk_valid`=`keys_valid`=0, and no `done` ever appears.
  - A subsequent start produces a correct full schedule.
- **Back-to-back.** Hold `start` high with the zero key, then the FIPS key.
  - Second `busy` rises at T+13.
  - Between expansions, `keys_valid` drops on acceptance and re-sets at the second `done`.
- **Macro on.** Repeat the FIPS case with `KEY_SCHED_SBOX_REG_EN`.
  - Identical values.
  - Beats at T+1, T+3, …, T+21; `done` at T+21.
